// File: rtl/multiport_bypass_buffer.sv
// Age-ordered result-forwarding buffer: captures up to WR_PORTS results per cycle and answers RD_PORTS tag lookups, youngest match wins.
// Latency: lookups are combinational from registered state (0 cycles); a write is visible from the cycle after its edge.
// Backpressure: none; writers never stall and overflow evicts the oldest entries. Optional macro BYPASS_WR_FWD_EN adds a same-cycle write-to-read path.
module multiport_bypass_buffer #(
   parameter int DATA_W   = 32,
   parameter int TAG_W    = 6,
   parameter int DEPTH    = 3,
   parameter int WR_PORTS = 2,
   parameter int RD_PORTS = 4,
   localparam int OCC_W   = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [WR_PORTS-1:0]          wr_valid,
   input  logic [WR_PORTS*TAG_W-1:0]    wr_tag,
   input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
   input  logic [RD_PORTS*TAG_W-1:0]    rd_tag,
   output logic [RD_PORTS-1:0]          rd_hit,
   output logic [RD_PORTS*DATA_W-1:0]   rd_data,
   output logic [OCC_W-1:0]             occupancy
);

   // Entry storage; index 0 holds the youngest result.
   logic [DEPTH-1:0]  ent_valid;
   logic [TAG_W-1:0]  ent_tag  [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [OCC_W-1:0]  occ;

   logic [DEPTH-1:0]  nxt_valid;
   logic [TAG_W-1:0]  nxt_tag  [DEPTH];
   logic [DATA_W-1:0] nxt_data [DEPTH];
   logic [OCC_W-1:0]  nxt_occ;

   logic [WR_PORTS-1:0] eff;
   int                  rank [WR_PORTS];
   int                  k;
   int                  occ_sum;

   // Compact accepted writes (tag != 0) so the highest port lands in slot 0, then shift old entries down by k.
   always_comb begin
      k = 0;
      for (int p = 0; p < WR_PORTS; p++) begin
         eff[p] = wr_valid[p] && (wr_tag[p*TAG_W +: TAG_W] != '0);
      end
      for (int p = 0; p < WR_PORTS; p++) begin
         rank[p] = 0;
         for (int q = p + 1; q < WR_PORTS; q++) begin
            if (eff[q]) rank[p] = rank[p] + 1;
         end
         if (eff[p]) k = k + 1;
      end
      for (int i = 0; i < DEPTH; i++) begin
         nxt_valid[i] = 1'b0;
         nxt_tag[i]   = '0;
         nxt_data[i]  = '0;
         if (i < k) begin
            for (int p = 0; p < WR_PORTS; p++) begin
               if (eff[p] && (rank[p] == i)) begin
                  nxt_valid[i] = 1'b1;
                  nxt_tag[i]   = wr_tag[p*TAG_W +: TAG_W];
                  nxt_data[i]  = wr_data[p*DATA_W +: DATA_W];
               end
            end
         end else begin
            for (int j = 0; j < DEPTH; j++) begin
               if (j + k == i) begin
                  nxt_valid[i] = ent_valid[j];
                  nxt_tag[i]   = ent_tag[j];
                  nxt_data[i]  = ent_data[j];
               end
            end
         end
      end
      occ_sum = int'(occ) + k;
      if (occ_sum > DEPTH) occ_sum = DEPTH;
      nxt_occ = OCC_W'(occ_sum);
   end

   // Entry registers: async clear on reset, full clear on flush (flush beats same-edge writes).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid <= '0;
         occ       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_tag[i]  <= '0;
            ent_data[i] <= '0;
         end
      end else if (flush) begin
         ent_valid <= '0;
         occ       <= '0;
      end else begin
         ent_valid <= nxt_valid;
         occ       <= nxt_occ;
         for (int i = 0; i < DEPTH; i++) begin
            ent_tag[i]  <= nxt_tag[i];
            ent_data[i] <= nxt_data[i];
         end
      end
   end

   assign occupancy = occ;

   logic [TAG_W-1:0]  rt;
   logic              hit;
   logic [DATA_W-1:0] dat;

   // Lookup: scan oldest to youngest so the lowest matching index wins; same-cycle writes override when enabled.
   always_comb begin
      rt      = '0;
      hit     = 1'b0;
      dat     = '0;
      rd_hit  = '0;
      rd_data = '0;
      for (int r = 0; r < RD_PORTS; r++) begin
         rt  = rd_tag[r*TAG_W +: TAG_W];
         hit = 1'b0;
         dat = '0;
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_tag[i] == rt) && (rt != '0)) begin
               hit = 1'b1;
               dat = ent_data[i];
            end
         end
`ifdef BYPASS_WR_FWD_EN
         // Higher write port is younger, so it is applied last.
         for (int p = 0; p < WR_PORTS; p++) begin
            if (!rst && wr_valid[p] && (wr_tag[p*TAG_W +: TAG_W] == rt) && (rt != '0)) begin
               hit = 1'b1;
               dat = wr_data[p*DATA_W +: DATA_W];
            end
         end
`endif
         rd_hit[r]                   = hit;
         rd_data[r*DATA_W +: DATA_W] = dat;
      end
   end

endmodule

// File: tb/tb_multiport_bypass_buffer.sv
// Self-checking bench for multiport_bypass_buffer: directed cases plus random traffic.
// Expected lookup results come from a queue-based reference model pushed to a scoreboard when driven.
// Outputs are sampled mid-cycle, away from the rising edge.
module tb_multiport_bypass_buffer;
   localparam int DATA_W = 32, TAG_W = 6, DEPTH = 3, WR_PORTS = 2, RD_PORTS = 4;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       flush = 1'b0;
   logic [WR_PORTS-1:0]        wr_valid = '0;
   logic [WR_PORTS*TAG_W-1:0]  wr_tag = '0;
   logic [WR_PORTS*DATA_W-1:0] wr_data = '0;
   logic [RD_PORTS*TAG_W-1:0]  rd_tag = '0;
   logic [RD_PORTS-1:0]        rd_hit;
   logic [RD_PORTS*DATA_W-1:0] rd_data;
   logic [OCC_W-1:0]           occupancy;

   multiport_bypass_buffer #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .WR_PORTS(WR_PORTS), .RD_PORTS(RD_PORTS)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_tag(wr_tag),
      .wr_data(wr_data), .rd_tag(rd_tag), .rd_hit(rd_hit), .rd_data(rd_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } ent_t;

   typedef struct packed {
      logic [RD_PORTS-1:0]        hit;
      logic [RD_PORTS*DATA_W-1:0] data;
      logic [OCC_W-1:0]           occ;
   } exp_t;

   ent_t model_q[$];
   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference lookup: same-cycle writes first (when enabled, youngest port first), then stored entries youngest first.
   function automatic exp_t predict(input logic [WR_PORTS-1:0] wv, input logic [WR_PORTS*TAG_W-1:0] wt,
                                    input logic [WR_PORTS*DATA_W-1:0] wd, input logic [RD_PORTS*TAG_W-1:0] rt);
      exp_t e;
      e = '0;
      e.occ = OCC_W'(model_q.size());
      for (int r = 0; r < RD_PORTS; r++) begin
         logic [TAG_W-1:0] t;
         logic found;
         t = rt[r*TAG_W +: TAG_W];
         found = 1'b0;
         if (t != 0) begin
`ifdef BYPASS_WR_FWD_EN
            for (int p = WR_PORTS - 1; p >= 0; p--) begin
               if (!found && wv[p] && wt[p*TAG_W +: TAG_W] == t) begin
                  found = 1'b1;
                  e.data[r*DATA_W +: DATA_W] = wd[p*DATA_W +: DATA_W];
               end
            end
`endif
            for (int i = 0; i < model_q.size(); i++) begin
               if (!found && model_q[i].tag == t) begin
                  found = 1'b1;
                  e.data[r*DATA_W +: DATA_W] = model_q[i].data;
               end
            end
         end
         e.hit[r] = found;
      end
      return e;
   endfunction

   // Drive one cycle, score the mid-cycle outputs, then advance the model across the edge.
   task automatic step(input string name, input logic [WR_PORTS-1:0] wv, input logic [WR_PORTS*TAG_W-1:0] wt,
                       input logic [WR_PORTS*DATA_W-1:0] wd, input logic [RD_PORTS*TAG_W-1:0] rt,
                       input logic fl);
      exp_t e;
      @(negedge clk);
      wr_valid = wv; wr_tag = wt; wr_data = wd; rd_tag = rt; flush = fl;
      exp_q.push_back(predict(wv, wt, wd, rt));
      #2;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         chk({name, ".occ"}, 64'(occupancy), 64'(e.occ));
         for (int r = 0; r < RD_PORTS; r++) begin
            chk($sformatf("%s.hit%0d", name, r), 64'(rd_hit[r]), 64'(e.hit[r]));
            chk($sformatf("%s.data%0d", name, r), 64'(rd_data[r*DATA_W +: DATA_W]),
                64'(e.data[r*DATA_W +: DATA_W]));
         end
      end
      @(posedge clk);
      if (fl) model_q.delete();
      else begin
         for (int p = 0; p < WR_PORTS; p++) begin
            if (wv[p] && wt[p*TAG_W +: TAG_W] != 0)
               model_q.push_front('{tag: wt[p*TAG_W +: TAG_W], data: wd[p*DATA_W +: DATA_W]});
         end
         while (model_q.size() > DEPTH) void'(model_q.pop_back());
      end
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst.occ", 64'(occupancy), 64'd0);
      chk("rst.hit", 64'(rd_hit), 64'd0);
      chk("rst.data", 64'(rd_data), 64'd0);
      @(negedge clk); rst = 1'b0;

      // Case 1: single write then lookup
      step("c1w", 2'b01, {6'd0, 6'd5}, {32'h0, 32'hAA}, {6'd0, 6'd0, 6'd0, 6'd5}, 1'b0);
      step("c1r", 2'b00, '0, '0, {6'd0, 6'd0, 6'd0, 6'd5}, 1'b0);

      // Case 2: overflow evicts the oldest
      for (int t = 1; t <= 4; t++)
         step("c2w", 2'b01, {6'd0, 6'(t)}, {32'h0, 32'(t * 16 + 1)}, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0);
      step("c2r", 2'b00, '0, '0, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0);

      // Case 3: same tag on both ports, higher port wins
      step("c3f", 2'b00, '0, '0, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b1);
      step("c3w", 2'b11, {6'd7, 6'd7}, {32'h22, 32'h11}, {6'd0, 6'd0, 6'd0, 6'd7}, 1'b0);
      step("c3r", 2'b00, '0, '0, {6'd0, 6'd0, 6'd7, 6'd7}, 1'b0);

      // Case 4: fill, then flush with a simultaneous write
      step("c4w", 2'b11, {6'd12, 6'd11}, {32'hC, 32'hB}, {6'd12, 6'd11, 6'd9, 6'd7}, 1'b0);
      step("c4f", 2'b01, {6'd0, 6'd9}, {32'h0, 32'h99}, {6'd12, 6'd11, 6'd9, 6'd7}, 1'b1);
      step("c4r", 2'b00, '0, '0, {6'd12, 6'd11, 6'd9, 6'd7}, 1'b0);

      // Case 5: tag 0 writes are dropped
      step("c5p", 2'b01, {6'd0, 6'd3}, {32'h0, 32'h33}, {6'd0, 6'd0, 6'd0, 6'd0}, 1'b0);
      step("c5w", 2'b01, {6'd0, 6'd0}, {32'h0, 32'hFF}, {6'd0, 6'd0, 6'd3, 6'd0}, 1'b0);
      step("c5r", 2'b00, '0, '0, {6'd0, 6'd0, 6'd3, 6'd0}, 1'b0);

      // Case 6: same-cycle write and lookup
      step("c6w", 2'b10, {6'd6, 6'd0}, {32'h66, 32'h0}, {6'd0, 6'd3, 6'd6, 6'd6}, 1'b0);
      step("c6r", 2'b00, '0, '0, {6'd0, 6'd3, 6'd6, 6'd6}, 1'b0);

      // Random traffic with occasional flush
      for (int n = 0; n < 150; n++) begin
         logic [RD_PORTS*TAG_W-1:0] rt;
         logic [WR_PORTS*TAG_W-1:0] wt;
         for (int r = 0; r < RD_PORTS; r++) rt[r*TAG_W +: TAG_W] = 6'($urandom_range(0, 7));
         for (int p = 0; p < WR_PORTS; p++) wt[p*TAG_W +: TAG_W] = 6'($urandom_range(0, 7));
         step("rnd", 2'($urandom), wt, {$urandom, $urandom}, rt, ($urandom_range(0, 15) == 0));
      end

      // Reset mid-stream clears outputs immediately
      step("prer", 2'b11, {6'd2, 6'd1}, {32'h2, 32'h1}, {6'd0, 6'd0, 6'd2, 6'd1}, 1'b0);
      @(negedge clk);
      wr_valid = '0; flush = 1'b0; rd_tag = {6'd0, 6'd0, 6'd2, 6'd1};
      rst = 1'b1;
      #1;
      chk("mrst.occ", 64'(occupancy), 64'd0);
      chk("mrst.hit", 64'(rd_hit), 64'd0);
      chk("mrst.data", 64'(rd_data), 64'd0);
      model_q.delete();
      @(negedge clk); rst = 1'b0;
      step("post", 2'b00, '0, '0, {6'd0, 6'd0, 6'd2, 6'd1}, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
